// File: rtl/rv32i_control_pkg.sv
// Shared types for the multicycle RV32I control path.
// Holds the opcode/funct3 encodings seen from the IR, the ALU and comparator op codes,
// every datapath mux select, and the control FSM state. Every select enum has value 0
// as its idle/reset choice, so a zeroed control word is always a safe one.
package rv32i_control_pkg;

    localparam int unsigned Width = 32;

    typedef enum logic [6:0] {
        OpLoad  = 7'b0000011,
        OpImm   = 7'b0010011,
        OpAuipc = 7'b0010111,
        OpStore = 7'b0100011,
        OpReg   = 7'b0110011,
        OpLui   = 7'b0110111,
        OpBr    = 7'b1100011,
        OpJalr  = 7'b1100111,
        OpJal   = 7'b1101111
    } rv32i_opcode_t;

    typedef enum logic [2:0] {
        F3Add  = 3'b000,
        F3Sll  = 3'b001,
        F3Slt  = 3'b010,
        F3Sltu = 3'b011,
        F3Xor  = 3'b100,
        F3Sr   = 3'b101,
        F3Or   = 3'b110,
        F3And  = 3'b111
    } arith_funct3_t;

    typedef enum logic [2:0] {
        F3Sb = 3'b000,
        F3Sh = 3'b001,
        F3Sw = 3'b010
    } store_funct3_t;

    // Non-sub/sra codes line up with arith funct3 so they can be passed straight through.
    typedef enum logic [2:0] {
        AluAdd = 3'b000,
        AluSll = 3'b001,
        AluSra = 3'b010,
        AluSub = 3'b011,
        AluXor = 3'b100,
        AluSrl = 3'b101,
        AluOr  = 3'b110,
        AluAnd = 3'b111
    } alu_ops_t;

    // Matches branch funct3, so a branch drives cmpop directly from the IR.
    typedef enum logic [2:0] {
        CmpBeq  = 3'b000,
        CmpBne  = 3'b001,
        CmpBlt  = 3'b100,
        CmpBge  = 3'b101,
        CmpBltu = 3'b110,
        CmpBgeu = 3'b111
    } cmp_ops_t;

    typedef enum logic [1:0] {
        PcPlus4   = 2'b00,
        PcAluOut  = 2'b01,
        PcAluMod2 = 2'b10
    } pcmux_sel_t;

    typedef enum logic {
        MarPcOut  = 1'b0,
        MarAluOut = 1'b1
    } marmux_sel_t;

    typedef enum logic [3:0] {
        RfAluOut  = 4'd0,
        RfBrTake  = 4'd1,
        RfUImm    = 4'd2,
        RfLd      = 4'd3,
        RfPcPlus4 = 4'd4
    } regfilemux_sel_t;

    typedef enum logic {
        Alu1Rs1Out = 1'b0,
        Alu1PcOut  = 1'b1
    } alumux1_sel_t;

    typedef enum logic [2:0] {
        Alu2IImm   = 3'd0,
        Alu2UImm   = 3'd1,
        Alu2BImm   = 3'd2,
        Alu2SImm   = 3'd3,
        Alu2JImm   = 3'd4,
        Alu2Rs2Out = 3'd5
    } alumux2_sel_t;

    typedef enum logic {
        CmpRs2Out = 1'b0,
        CmpIImm   = 1'b1
    } cmpmux_sel_t;

    typedef enum logic [3:0] {
        StFetch1,
        StFetch2,
        StFetch3,
        StDecode,
        StImm,
        StReg,
        StLui,
        StAuipc,
        StBr,
        StJal,
        StJalr,
        StCalcAddr,
        StLd1,
        StLd2,
        StSt1,
        StSt2
    } state_t;

    // ALU op for register/immediate arithmetic. funct7[5] picks sra over srl for shifts,
    // and sub over add only for register-register ops (for addi that bit is immediate data).
    function automatic alu_ops_t arith_aluop(logic [2:0] funct3, logic alt, logic allow_sub);
        alu_ops_t op;
        case (funct3)
            F3Add: begin
                if (alt && allow_sub) op = AluSub;
                else                  op = AluAdd;
            end
            F3Sr: begin
                if (alt) op = AluSra;
                else     op = AluSrl;
            end
            default: op = alu_ops_t'(funct3);
        endcase
        return op;
    endfunction

endpackage

// File: rtl/rv32i_store_mask.sv
// Store byte-lane mask generator.
// Ports:
//   funct3      in  3  store width from the IR (sb/sh/sw)
//   addr_lo     in  2  low bits of the effective address
//   byte_enable out 4  write lane mask for the memory port
module rv32i_store_mask
    import rv32i_control_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic [1:0] addr_lo,
    output logic [3:0] byte_enable
);

    always_comb begin
        case (funct3)
            F3Sb:    byte_enable = 4'b0001 << addr_lo;
            // Halfword lanes follow the aligned half; addr_lo[0] is ignored.
            F3Sh:    byte_enable = 4'b0011 << {addr_lo[1], 1'b0};
            default: byte_enable = 4'b1111;
        endcase
    end

endmodule

// File: rtl/rv32i_control.sv
// Multicycle RV32I control FSM.
// Sequences fetch / decode / execute / memory for each instruction and drives every
// datapath load enable, mux select and ALU/CMP op. Owns the request side of the unified
// memory port: mem_read / mem_write are held until the one-cycle mem_resp pulse.
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   opcode, funct3, funct7         IR fields
//   br_en                          comparator result for the current cmpop
//   mem_addr_lo                    alu_out[1:0], selects store byte lanes
//   mem_resp                       memory done pulse
//   load_*                         register load enables
//   *_sel, aluop, cmpop            datapath mux selects and ops
//   mem_read, mem_write            memory requests
//   mem_byte_enable                write lane mask (all lanes when not storing)
//   illegal_insn                   one-cycle pulse on an undecodable opcode
module rv32i_control
    import rv32i_control_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic [6:0]      opcode,
    input  logic [2:0]      funct3,
    input  logic [6:0]      funct7,
    input  logic            br_en,
    input  logic [1:0]      mem_addr_lo,
    input  logic            mem_resp,
    output logic            load_pc,
    output logic            load_ir,
    output logic            load_regfile,
    output logic            load_mar,
    output logic            load_mdr,
    output logic            load_data_out,
    output pcmux_sel_t      pcmux_sel,
    output marmux_sel_t     marmux_sel,
    output regfilemux_sel_t regfilemux_sel,
    output alumux1_sel_t    alumux1_sel,
    output alumux2_sel_t    alumux2_sel,
    output cmpmux_sel_t     cmpmux_sel,
    output alu_ops_t        aluop,
    output cmp_ops_t        cmpop,
    output logic            mem_read,
    output logic            mem_write,
    output logic [3:0]      mem_byte_enable,
    output logic            illegal_insn
);

    state_t     state_q, state_d;
    logic [3:0] store_mask;

    // Only funct7[5] carries control meaning.
    logic unused_funct7;
    assign unused_funct7 = ^{funct7[6], funct7[4:0]};

    rv32i_store_mask u_store_mask (
        .funct3      (funct3),
        .addr_lo     (mem_addr_lo),
        .byte_enable (store_mask)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= StFetch1;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d         = state_q;
        load_pc         = 1'b0;
        load_ir         = 1'b0;
        load_regfile    = 1'b0;
        load_mar        = 1'b0;
        load_mdr        = 1'b0;
        load_data_out   = 1'b0;
        pcmux_sel       = PcPlus4;
        marmux_sel      = MarPcOut;
        regfilemux_sel  = RfAluOut;
        alumux1_sel     = Alu1Rs1Out;
        alumux2_sel     = Alu2IImm;
        cmpmux_sel      = CmpRs2Out;
        aluop           = AluAdd;
        cmpop           = CmpBeq;
        mem_read        = 1'b0;
        mem_write       = 1'b0;
        mem_byte_enable = 4'hF;
        illegal_insn    = 1'b0;

        // Gating on rst_n drops any in-flight request the moment reset asserts.
        if (rst_n) begin
            unique case (state_q)
                StFetch1: begin
                    load_mar = 1'b1;
                    state_d  = StFetch2;
                end
                StFetch2: begin
                    mem_read = 1'b1;
                    if (mem_resp) begin
                        load_mdr = 1'b1;
                        state_d  = StFetch3;
                    end
                end
                StFetch3: begin
                    load_ir = 1'b1;
                    state_d = StDecode;
                end
                StDecode: begin
                    case (opcode)
                        OpImm:            state_d = StImm;
                        OpReg:            state_d = StReg;
                        OpLui:            state_d = StLui;
                        OpAuipc:          state_d = StAuipc;
                        OpBr:             state_d = StBr;
                        OpJal:            state_d = StJal;
                        OpJalr:           state_d = StJalr;
                        OpLoad, OpStore:  state_d = StCalcAddr;
                        default: begin
                            // Skip the instruction: advance PC, leave the regfile alone.
                            illegal_insn = 1'b1;
                            load_pc      = 1'b1;
                            state_d      = StFetch1;
                        end
                    endcase
                end
                StImm, StReg: begin
                    load_regfile = 1'b1;
                    load_pc      = 1'b1;
                    state_d      = StFetch1;
                    if (funct3 == F3Slt || funct3 == F3Sltu) begin
                        // Set-less-than goes through the comparator, not the ALU.
                        if (funct3 == F3Slt) cmpop = CmpBlt;
                        else                 cmpop = CmpBltu;
                        if (state_q == StImm) cmpmux_sel = CmpIImm;
                        regfilemux_sel = RfBrTake;
                    end else begin
                        if (state_q == StImm) alumux2_sel = Alu2IImm;
                        else                  alumux2_sel = Alu2Rs2Out;
                        aluop = arith_aluop(funct3, funct7[5], state_q == StReg);
                    end
                end
                StLui: begin
                    regfilemux_sel = RfUImm;
                    load_regfile   = 1'b1;
                    load_pc        = 1'b1;
                    state_d        = StFetch1;
                end
                StAuipc: begin
                    alumux1_sel  = Alu1PcOut;
                    alumux2_sel  = Alu2UImm;
                    load_regfile = 1'b1;
                    load_pc      = 1'b1;
                    state_d      = StFetch1;
                end
                StBr: begin
                    cmpop       = cmp_ops_t'(funct3);
                    alumux1_sel = Alu1PcOut;
                    alumux2_sel = Alu2BImm;
                    load_pc     = 1'b1;
                    if (br_en) pcmux_sel = PcAluOut;
                    state_d     = StFetch1;
                end
                StJal: begin
                    regfilemux_sel = RfPcPlus4;
                    alumux1_sel    = Alu1PcOut;
                    alumux2_sel    = Alu2JImm;
                    pcmux_sel      = PcAluOut;
                    load_regfile   = 1'b1;
                    load_pc        = 1'b1;
                    state_d        = StFetch1;
                end
                StJalr: begin
                    regfilemux_sel = RfPcPlus4;
                    pcmux_sel      = PcAluMod2;
                    load_regfile   = 1'b1;
                    load_pc        = 1'b1;
                    state_d        = StFetch1;
                end
                StCalcAddr: begin
                    marmux_sel = MarAluOut;
                    load_mar   = 1'b1;
                    if (opcode == OpStore) begin
                        alumux2_sel   = Alu2SImm;
                        load_data_out = 1'b1;
                        state_d       = StSt1;
                    end else begin
                        state_d = StLd1;
                    end
                end
                StLd1: begin
                    mem_read = 1'b1;
                    if (mem_resp) begin
                        load_mdr = 1'b1;
                        state_d  = StLd2;
                    end
                end
                StLd2: begin
                    regfilemux_sel = RfLd;
                    load_regfile   = 1'b1;
                    load_pc        = 1'b1;
                    state_d        = StFetch1;
                end
                StSt1: begin
                    mem_write       = 1'b1;
                    mem_byte_enable = store_mask;
                    if (mem_resp) state_d = StSt2;
                end
                StSt2: begin
                    load_pc = 1'b1;
                    state_d = StFetch1;
                end
            endcase
        end
    end

endmodule
